snake_game_ctrl: RTL



---
 rtl/snake_pkg.sv | 34 +++
 rtl/snake_lfsr12.sv | 23 ++
 rtl/snake_game_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared definitions for the snake game blocks: game and eat state encodings,
// playfield/body constants, renderer cell codes and a playfield range helper.
package snake_pkg;

  typedef enum logic [1:0] {
    ST_START,
    ST_PLAY,
    ST_DIE,
    ST_WIN
  } game_state_e;

  typedef enum logic [1:0] {
    E_IDLE,
    E_PULSE,
    E_RELOC
  } eat_state_e;

  typedef enum logic [1:0] {
    CELL_NONE,
    CELL_HEAD,
    CELL_BODY,
    CELL_WALL
  } cell_e;

  localparam logic [5:0] X_MAX   = 6'd38;  // playfield x = 1..X_MAX
  localparam logic [5:0] Y_MAX   = 6'd28;  // playfield y = 1..Y_MAX
  localparam logic [6:0] MAX_LEN = 7'd16;  // body store capacity

  // True when (x, y) lies inside the playable area (border cells excluded).
  function automatic logic in_field(input logic [5:0] x, input logic [5:0] y);
    return (x >= 6'd1) && (x <= X_MAX) && (y >= 6'd1) && (y <= Y_MAX);
  endfunction

endpackage

// File: rtl/snake_lfsr12.sv
// 12-bit Fibonacci LFSR, taps 12,11,10,4, free-running every cycle.
// Ports: clk, clr (sync active-high, loads SEED), lfsr (current value).
// The update is invertible, so a nonzero seed never reaches the all-zero lockup.
module snake_lfsr12 #(
  parameter logic [11:0] SEED = 12'hACE
) (
  input  logic        clk,
  input  logic        clr,
  output logic [11:0] lfsr
);

  logic fb;

  assign fb = lfsr[11] ^ lfsr[10] ^ lfsr[9] ^ lfsr[3];

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (clr) lfsr <= SEED;
    else     lfsr <= {lfsr[10:0], fb};
  end

endmodule

// File: rtl/snake_game_ctrl.sv
// Game-level sequencer for the snake datapath: START/PLAY/DIE/WIN FSM, apple
// eating with a held grow request, LFSR apple relocation and saturating score.
// Ports:
//   clk, clr            clock, synchronous active-high reset
//   start_btn           level button, acted on at its rising edge
//   head_x/head_y       datapath head cell
//   hit_wall/hit_body   datapath collision flags
//   cube_num            datapath current length
//   snake_clr           datapath clear, high throughout START
//   s_start/s_play/s_die, game_win   one-hot state qualifiers (+ win flag)
//   add_cube            grow request, ADD_HOLD cycles per apple
//   apple_x/apple_y/apple_valid      apple cell and its displayable flag
//   score               apples eaten, saturating at 255
// All outputs are registered from the next-state logic.
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter logic [3:0]  ADD_HOLD  = 4'd2,
  parameter logic [5:0]  APPLE_X0  = 6'd20,
  parameter logic [5:0]  APPLE_Y0  = 6'd15,
  parameter logic [11:0] LFSR_SEED = 12'hACE
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start_btn,
  input  logic [5:0] head_x,
  input  logic [5:0] head_y,
  input  logic       hit_wall,
  input  logic       hit_body,
  input  logic [6:0] cube_num,
  output logic       snake_clr,
  output logic       s_start,
  output logic       s_play,
  output logic       s_die,
  output logic       game_win,
  output logic       add_cube,
  output logic [5:0] apple_x,
  output logic [5:0] apple_y,
  output logic       apple_valid,
  output logic [7:0] score
);

  game_state_e state, state_d;
  eat_state_e  eat, eat_d;
  logic [3:0]  hold_cnt, hold_d;
  logic        start_q, btn_rise;
  logic        add_d, valid_d;
  logic [5:0]  apple_x_d, apple_y_d, cand_x, cand_y;
  logic [7:0]  score_d;
  logic [11:0] lfsr;

  snake_lfsr12 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk  (clk),
    .clr  (clr),
    .lfsr (lfsr)
  );

  assign btn_rise = start_btn & ~start_q;
  assign cand_x   = lfsr[5:0];
  assign cand_y   = lfsr[11:6];

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state;
    eat_d     = eat;
    hold_d    = hold_cnt;
    add_d     = 1'b0;
    valid_d   = apple_valid;
    apple_x_d = apple_x;
    apple_y_d = apple_y;
    score_d   = score;
    unique case (state)
      ST_START: begin
        if (btn_rise) begin
          state_d   = ST_PLAY;
          eat_d     = E_IDLE;
          score_d   = 8'd0;
          apple_x_d = APPLE_X0;
          apple_y_d = APPLE_Y0;
          valid_d   = 1'b1;
        end
      end
      ST_PLAY: begin
        // Priority: collision, then win, then eating. Leaving PLAY drops
        // add_cube (default 0) and parks the eat sub-FSM.
        if (hit_wall | hit_body) begin
          state_d = ST_DIE;
          eat_d   = E_IDLE;
        end else if (cube_num >= MAX_LEN) begin
          state_d = ST_WIN;
          eat_d   = E_IDLE;
        end else begin
          unique case (eat)
            E_IDLE: begin
              if (apple_valid && head_x == apple_x && head_y == apple_y) begin
                eat_d   = E_PULSE;
                add_d   = 1'b1;
                hold_d  = ADD_HOLD - 4'd1;
                valid_d = 1'b0;
                score_d = (score == 8'hFF) ? score : score + 8'd1;
              end
            end
            E_PULSE: begin
              // hold_cnt counts the remaining high cycles after the first.
              if (hold_cnt == 4'd0) begin
                eat_d = E_RELOC;
              end else begin
                add_d  = 1'b1;
                hold_d = hold_cnt - 4'd1;
              end
            end
            E_RELOC: begin
              if (in_field(cand_x, cand_y) && !(cand_x == head_x && cand_y == head_y)) begin
                apple_x_d = cand_x;
                apple_y_d = cand_y;
                valid_d   = 1'b1;
                eat_d     = E_IDLE;
              end
            end
            default: eat_d = E_IDLE;
          endcase
        end
      end
      ST_DIE, ST_WIN: begin
        if (btn_rise) state_d = ST_START;
      end
      default: state_d = ST_START;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state       <= ST_START;
      eat         <= E_IDLE;
      hold_cnt    <= 4'd0;
      start_q     <= 1'b1;  // a button held through reset is not an edge
      add_cube    <= 1'b0;
      apple_x     <= APPLE_X0;
      apple_y     <= APPLE_Y0;
      apple_valid <= 1'b1;
      score       <= 8'd0;
      snake_clr   <= 1'b1;
      s_start     <= 1'b1;
      s_play      <= 1'b0;
      s_die       <= 1'b0;
      game_win    <= 1'b0;
    end else begin
      state       <= state_d;
      eat         <= eat_d;
      hold_cnt    <= hold_d;
      start_q     <= start_btn;
      add_cube    <= add_d;
      apple_x     <= apple_x_d;
      apple_y     <= apple_y_d;
      apple_valid <= valid_d;
      score       <= score_d;
      snake_clr   <= (state_d == ST_START);
      s_start     <= (state_d == ST_START);
      s_play      <= (state_d == ST_PLAY);
      s_die       <= (state_d == ST_DIE) || (state_d == ST_WIN);
      game_win    <= (state_d == ST_WIN);
    end
  end

endmodule
